// File: rtl/csm_controller_pkg.sv
// Shared types and error codes for the two-port shared-memory controller.
package csm_controller_pkg;

  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_WLOST  = 2'b01;
  localparam logic [1:0] ERR_NOLOCK = 2'b10;
  localparam logic [1:0] ERR_REHOLD = 2'b11;

  typedef enum logic [1:0] {IDLE, WDATA, HWAIT} port_state_t;
  typedef enum logic [1:0] {UNLOCKED, LOCK_A, LOCK_B} lock_state_t;
  typedef enum logic [2:0] {CMD_NONE, CMD_READ, CMD_WRITE, CMD_HOLD, CMD_REL} cmd_t;

  // Priority hold > release > read/write.
  function automatic cmd_t decode_cmd(input logic en, input logic hold,
                                      input logic rel, input logic rw);
    if (!en) return CMD_NONE;
    if (hold) return CMD_HOLD;
    if (rel) return CMD_REL;
    return rw ? CMD_WRITE : CMD_READ;
  endfunction

  function automatic lock_state_t owner_of(input int unsigned p);
    return (p == 0) ? LOCK_A : LOCK_B;
  endfunction

endpackage

// File: rtl/csm_controller_if.sv
// Processor A / processor B bus bundle between the CPUs (master) and the controller (slave).
interface csm_controller_if #(
  parameter int DATABITS = 8,
  parameter int ERRBITS  = 2
);
  logic [DATABITS-1:0] A_in_AD;
  logic                A_rw;
  logic                A_enable;
  logic                A_hold;
  logic                A_release;
  logic                A_ack;
  logic [ERRBITS-1:0]  A_err;
  logic [DATABITS-1:0] A_out_data;

  logic [DATABITS-1:0] B_in_AD;
  logic                B_rw;
  logic                B_enable;
  logic                B_hold;
  logic                B_release;
  logic                B_ack;
  logic [ERRBITS-1:0]  B_err;
  logic [DATABITS-1:0] B_out_data;

  modport master (
    output A_in_AD, A_rw, A_enable, A_hold, A_release,
    output B_in_AD, B_rw, B_enable, B_hold, B_release,
    input  A_ack, A_err, A_out_data,
    input  B_ack, B_err, B_out_data
  );

  modport slave (
    input  A_in_AD, A_rw, A_enable, A_hold, A_release,
    input  B_in_AD, B_rw, B_enable, B_hold, B_release,
    output A_ack, A_err, A_out_data,
    output B_ack, B_err, B_out_data
  );
endinterface

// File: rtl/csm_controller_mem_dp.sv
// Two-read/two-write synchronous RAM; reads return pre-write data, port A wins same-address writes.
module csm_mem_dp #(
  parameter int DATABITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                re_a_i,
  input  logic [DATABITS-1:0] raddr_a_i,
  output logic [DATABITS-1:0] rdata_a_o,
  input  logic                re_b_i,
  input  logic [DATABITS-1:0] raddr_b_i,
  output logic [DATABITS-1:0] rdata_b_o,
  input  logic                we_a_i,
  input  logic [DATABITS-1:0] waddr_a_i,
  input  logic [DATABITS-1:0] wdata_a_i,
  input  logic                we_b_i,
  input  logic [DATABITS-1:0] waddr_b_i,
  input  logic [DATABITS-1:0] wdata_b_i,
  output logic                collision_o
);
  localparam int unsigned DEPTH = 2 ** DATABITS;

  logic [DATABITS-1:0] mem_q [DEPTH];

  assign collision_o = we_a_i && we_b_i && (waddr_a_i == waddr_b_i);

  always_ff @(posedge clk) begin
    if (we_a_i) mem_q[waddr_a_i] <= wdata_a_i;
    if (we_b_i && !collision_o) mem_q[waddr_b_i] <= wdata_b_i;
  end

  // Read registers hold their value until the next read on that port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a_o <= '0;
      rdata_b_o <= '0;
    end else begin
      if (re_a_i) rdata_a_o <= mem_q[raddr_a_i];
      if (re_b_i) rdata_b_o <= mem_q[raddr_b_i];
    end
  end
endmodule

// File: rtl/csm_controller.sv
// Shared-memory controller: two command ports, exclusive hold/release lock, one shared RAM.
module csm_controller
  import csm_controller_pkg::*;
#(
  parameter int DATABITS = 8,
  parameter int ERRBITS  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  csm_controller_if.slave  bus
);

  logic [DATABITS-1:0] in_ad [2];
  logic                en    [2];
  logic                rw    [2];
  logic                hold  [2];
  logic                rel   [2];
  logic                ack   [2];
  logic                acc   [2];
  cmd_t                cmd   [2];

  port_state_t         st_q   [2];
  port_state_t         st_d   [2];
  logic [DATABITS-1:0] addr_q [2];
  logic [DATABITS-1:0] addr_d [2];
  logic [ERRBITS-1:0]  err_q  [2];
  logic [ERRBITS-1:0]  err_d  [2];
  lock_state_t         lock_q, lock_d;
  logic [1:0]          grant;

  logic                re    [2];
  logic                we    [2];
  logic [DATABITS-1:0] raddr [2];
  logic [DATABITS-1:0] waddr [2];
  logic [DATABITS-1:0] wdata [2];
  logic [DATABITS-1:0] rdata [2];
  logic                collision;

  assign in_ad[0] = bus.A_in_AD;
  assign en[0]    = bus.A_enable;
  assign rw[0]    = bus.A_rw;
  assign hold[0]  = bus.A_hold;
  assign rel[0]   = bus.A_release;
  assign in_ad[1] = bus.B_in_AD;
  assign en[1]    = bus.B_enable;
  assign rw[1]    = bus.B_rw;
  assign hold[1]  = bus.B_hold;
  assign rel[1]   = bus.B_release;

  assign bus.A_ack      = ack[0];
  assign bus.A_err      = err_q[0];
  assign bus.A_out_data = rdata[0];
  assign bus.B_ack      = ack[1];
  assign bus.B_err      = err_q[1];
  assign bus.B_out_data = rdata[1];

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      ack[p] = (st_q[p] == IDLE) && (lock_q == UNLOCKED || lock_q == owner_of(p));
      cmd[p] = decode_cmd(en[p], hold[p], rel[p], rw[p]);
      acc[p] = ack[p] && (cmd[p] != CMD_NONE);
    end
  end

  // Memory-side controls depend only on registered state and accepted commands,
  // keeping the write-collision flag free of any path through next-state logic.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      re[p]    = acc[p] && (cmd[p] == CMD_READ);
      raddr[p] = in_ad[p];
      we[p]    = (st_q[p] == WDATA);
      waddr[p] = addr_q[p];
      wdata[p] = in_ad[p];
    end
  end

  always_comb begin
    lock_d = lock_q;
    grant  = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      st_d[p]   = st_q[p];
      addr_d[p] = addr_q[p];
      err_d[p]  = err_q[p];
    end

    // A port already waiting outranks fresh holds; A outranks B otherwise.
    if (lock_q == UNLOCKED) begin
      if (st_q[0] == HWAIT)                      grant = 2'b01;
      else if (st_q[1] == HWAIT)                 grant = 2'b10;
      else if (acc[0] && cmd[0] == CMD_HOLD)     grant = 2'b01;
      else if (acc[1] && cmd[1] == CMD_HOLD)     grant = 2'b10;
    end
    if (grant[0])      lock_d = LOCK_A;
    else if (grant[1]) lock_d = LOCK_B;

    for (int unsigned p = 0; p < 2; p++) begin
      unique case (st_q[p])
        IDLE: begin
          if (acc[p]) begin
            unique case (cmd[p])
              CMD_READ:  err_d[p] = ERRBITS'(ERR_OK);
              CMD_WRITE: begin
                addr_d[p] = in_ad[p];
                st_d[p]   = WDATA;
              end
              CMD_HOLD: begin
                if (lock_q == owner_of(p)) err_d[p] = ERRBITS'(ERR_REHOLD);
                else if (grant[p])         err_d[p] = ERRBITS'(ERR_OK);
                else                       st_d[p]  = HWAIT;
              end
              CMD_REL: begin
                if (lock_q == owner_of(p)) begin
                  lock_d   = UNLOCKED;
                  err_d[p] = ERRBITS'(ERR_OK);
                end else begin
                  err_d[p] = ERRBITS'(ERR_NOLOCK);
                end
              end
              default: ;
            endcase
          end
        end
        WDATA: begin
          st_d[p]  = IDLE;
          err_d[p] = ((p == 1) && collision) ? ERRBITS'(ERR_WLOST) : ERRBITS'(ERR_OK);
        end
        HWAIT: begin
          if (grant[p]) begin
            st_d[p]  = IDLE;
            err_d[p] = ERRBITS'(ERR_OK);
          end
        end
        default: st_d[p] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q <= UNLOCKED;
      for (int unsigned p = 0; p < 2; p++) begin
        st_q[p]   <= IDLE;
        addr_q[p] <= '0;
        err_q[p]  <= '0;
      end
    end else begin
      lock_q <= lock_d;
      for (int unsigned p = 0; p < 2; p++) begin
        st_q[p]   <= st_d[p];
        addr_q[p] <= addr_d[p];
        err_q[p]  <= err_d[p];
      end
    end
  end

  csm_mem_dp #(.DATABITS(DATABITS)) u_mem (
    .clk         (clk),
    .rst_n       (reset_n),
    .re_a_i      (re[0]),
    .raddr_a_i   (raddr[0]),
    .rdata_a_o   (rdata[0]),
    .re_b_i      (re[1]),
    .raddr_b_i   (raddr[1]),
    .rdata_b_o   (rdata[1]),
    .we_a_i      (we[0]),
    .waddr_a_i   (waddr[0]),
    .wdata_a_i   (wdata[0]),
    .we_b_i      (we[1]),
    .waddr_b_i   (waddr[1]),
    .wdata_b_i   (wdata[1]),
    .collision_o (collision)
  );

endmodule
